// File: rtl/avg_filter_sequencer.sv
// rtl/avg_filter_sequencer.sv - sample sequencer for an enable-gated 3-stage averaging filter
module avg_filter_sequencer #(
  parameter int DATA_WIDTH = 24,
  parameter int PIPE_DEPTH = 3,
  parameter int FLUSH_LEN  = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  sample_valid,
  input  logic [DATA_WIDTH-1:0] sample_in,
  input  logic                  bypass,
  input  logic                  flush_req,
  output logic                  filt_enable,
  output logic [DATA_WIDTH-1:0] filt_signal,
  input  logic [DATA_WIDTH-1:0] filt_result,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_sample,
  output logic                  busy,
  output logic                  overrun
);

  localparam int FCW = (FLUSH_LEN > 1) ? $clog2(FLUSH_LEN) : 1;
  localparam int PCW = $clog2(PIPE_DEPTH + 1);
  localparam logic [FCW-1:0] FLUSH_LAST = FCW'(FLUSH_LEN - 1);
  localparam logic [PCW-1:0] PRIME_FULL = PCW'(PIPE_DEPTH);

  typedef enum logic [2:0] {
    ST_FLUSH,
    ST_IDLE,
    ST_ISSUE,
    ST_CAPTURE,
    ST_BYPASS
  } state_t;

  state_t                r_state;
  logic [FCW-1:0]        r_flush_cnt;
  logic [PCW-1:0]        r_prime_cnt;
  logic                  r_rearm;
  logic                  r_flush_pend;
  logic [DATA_WIDTH-1:0] r_pend;
  logic                  r_pend_v;
  logic                  r_overrun;
  logic                  r_filt_enable;
  logic [DATA_WIDTH-1:0] r_filt_signal;
  logic                  r_out_valid;
  logic [DATA_WIDTH-1:0] r_out_sample;
  logic                  r_busy;

  state_t                w_state_nxt;
  logic [FCW-1:0]        w_flush_cnt_nxt;
  logic [PCW-1:0]        w_prime_cnt_nxt;
  logic                  w_rearm_nxt;
  logic                  w_flush_pend_nxt;
  logic                  w_filt_enable_nxt;
  logic [DATA_WIDTH-1:0] w_filt_signal_nxt;
  logic                  w_out_valid_nxt;
  logic [DATA_WIDTH-1:0] w_out_sample_nxt;
  logic                  w_busy_nxt;
  logic                  w_consume;

  // Next state and next registered outputs; each state's action lands on the following cycle
  always_comb begin
    w_state_nxt       = r_state;
    w_flush_cnt_nxt   = r_flush_cnt;
    w_prime_cnt_nxt   = r_prime_cnt;
    w_rearm_nxt       = r_rearm;
    w_flush_pend_nxt  = r_flush_pend | flush_req;
    w_filt_enable_nxt = 1'b0;
    w_filt_signal_nxt = '0;
    w_out_valid_nxt   = 1'b0;
    w_out_sample_nxt  = r_out_sample;
    w_busy_nxt        = 1'b0;
    w_consume         = 1'b0;
    case (r_state)
      ST_FLUSH: begin
        w_filt_enable_nxt = 1'b1;
        w_busy_nxt        = 1'b1;
        w_rearm_nxt       = 1'b0;
        w_flush_pend_nxt  = 1'b0;
        if (flush_req) begin
          w_flush_cnt_nxt = '0;
        end else if (r_flush_cnt == FLUSH_LAST) begin
          w_flush_cnt_nxt = '0;
          w_prime_cnt_nxt = '0;
          w_state_nxt     = ST_IDLE;
        end else begin
          w_flush_cnt_nxt = r_flush_cnt + FCW'(1);
        end
      end
      ST_IDLE: begin
        if (flush_req || r_flush_pend) begin
          w_flush_cnt_nxt  = '0;
          w_flush_pend_nxt = 1'b0;
          w_state_nxt      = ST_FLUSH;
        end else if (r_pend_v && bypass) begin
          w_state_nxt = ST_BYPASS;
        end else if (r_pend_v && r_rearm) begin
          // filter history is stale after bypass; refill with zeros before issuing
          w_flush_cnt_nxt = '0;
          w_state_nxt     = ST_FLUSH;
        end else if (r_pend_v) begin
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        w_filt_enable_nxt = 1'b1;
        w_filt_signal_nxt = r_pend;
        w_consume         = 1'b1;
        if (r_prime_cnt != PRIME_FULL) begin
          w_prime_cnt_nxt = r_prime_cnt + PCW'(1);
        end
        w_state_nxt = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        if (r_prime_cnt == PRIME_FULL) begin
          w_out_sample_nxt = filt_result;
          w_out_valid_nxt  = 1'b1;
        end
        w_state_nxt = ST_IDLE;
      end
      ST_BYPASS: begin
        w_out_sample_nxt = r_pend;
        w_out_valid_nxt  = 1'b1;
        w_consume        = 1'b1;
        w_rearm_nxt      = 1'b1;
        w_state_nxt      = ST_IDLE;
      end
      default: begin
        w_flush_cnt_nxt = '0;
        w_state_nxt     = ST_FLUSH;
      end
    endcase
  end

  // FSM state, counters and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_FLUSH;
      r_flush_cnt   <= '0;
      r_prime_cnt   <= '0;
      r_rearm       <= 1'b0;
      r_flush_pend  <= 1'b0;
      r_filt_enable <= 1'b0;
      r_filt_signal <= '0;
      r_out_valid   <= 1'b0;
      r_out_sample  <= '0;
      r_busy        <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_flush_cnt   <= w_flush_cnt_nxt;
      r_prime_cnt   <= w_prime_cnt_nxt;
      r_rearm       <= w_rearm_nxt;
      r_flush_pend  <= w_flush_pend_nxt;
      r_filt_enable <= w_filt_enable_nxt;
      r_filt_signal <= w_filt_signal_nxt;
      r_out_valid   <= w_out_valid_nxt;
      r_out_sample  <= w_out_sample_nxt;
      r_busy        <= w_busy_nxt;
    end
  end

  // One-deep pending sample; a strobe into an unconsumed slot is dropped and flagged
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pend    <= '0;
      r_pend_v  <= 1'b0;
      r_overrun <= 1'b0;
    end else if (sample_valid) begin
      if (r_pend_v && !w_consume) begin
        r_overrun <= 1'b1;
      end else begin
        r_pend   <= sample_in;
        r_pend_v <= 1'b1;
      end
    end else if (w_consume) begin
      r_pend_v <= 1'b0;
    end
  end

  assign filt_enable = r_filt_enable;
  assign filt_signal = r_filt_signal;
  assign out_valid   = r_out_valid;
  assign out_sample  = r_out_sample;
  assign busy        = r_busy;
  assign overrun     = r_overrun;

endmodule
